// File: rtl/alu_pkg.sv
// Shared ALU definitions for the Booth multiplier: states, Booth action codes and step counts.
// Build option: BOOTH_BIT_PAIR_EN selects radix-4 bit-pair recoding; otherwise radix-2 Booth.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_ADD_M  = 3'd1,
        ACT_SUB_M  = 3'd2,
        ACT_ADD_2M = 3'd3,
        ACT_SUB_2M = 3'd4
    } booth_act_t;

`ifdef BOOTH_BIT_PAIR_EN
    localparam int RADIX_SHIFT = 2;
    localparam int RECODE_BITS = 3;
`else
    localparam int RADIX_SHIFT = 1;
    localparam int RECODE_BITS = 2;
`endif

    // Each Booth step retires RADIX_SHIFT multiplier bits.
    function automatic int booth_steps(input int w);
        return w / RADIX_SHIFT;
    endfunction

    localparam int BOOTH_STEPS = booth_steps(WIDTH_DEFAULT);

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
interface booth_multiplier_if #(
    parameter int WIDTH = alu_pkg::WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/booth_recoder.sv
// Combinational Booth recoder: multiplier low bits plus Q-1 to an add/sub action.
// Build option: BOOTH_BIT_PAIR_EN selects the radix-4 table; otherwise the radix-2 table.
module booth_recoder
    import alu_pkg::*;
(
    input  logic [RECODE_BITS-1:0] bits,
    output booth_act_t             act
);

`ifdef BOOTH_BIT_PAIR_EN
    // Radix-4 table over (Q1, Q0, Q-1).
    always_comb begin
        act = ACT_NONE;
        case (bits)
            3'b000:  act = ACT_NONE;
            3'b001:  act = ACT_ADD_M;
            3'b010:  act = ACT_ADD_M;
            3'b011:  act = ACT_ADD_2M;
            3'b100:  act = ACT_SUB_2M;
            3'b101:  act = ACT_SUB_M;
            3'b110:  act = ACT_SUB_M;
            3'b111:  act = ACT_NONE;
            default: act = ACT_NONE;
        endcase
    end
`else
    // Radix-2 table over (Q0, Q-1).
    always_comb begin
        act = ACT_NONE;
        case (bits)
            2'b01:   act = ACT_ADD_M;
            2'b10:   act = ACT_SUB_M;
            default: act = ACT_NONE;
        endcase
    end
`endif

endmodule

// File: rtl/booth_multiplier.sv
// Multi-cycle signed WIDTHxWIDTH->2*WIDTH Booth multiplier with start/busy/done handshake.
// Build option: BOOTH_BIT_PAIR_EN halves the step count with radix-4 recoding.
module booth_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              clr,
    booth_multiplier_if.slave bus
);

    // Two guard bits keep A +/- 2M and the negation of the most negative M in range.
    localparam int AW    = WIDTH + 2;
    localparam int STEPS = booth_steps(WIDTH);
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [AW-1:0]           a_r;
    logic [WIDTH-1:0]        q_r;
    logic                    qm1_r;
    logic [WIDTH-1:0]        m_r;
    logic                    busy_r;
    logic                    done_r;
    logic [WIDTH-1:0]        hi_r;
    logic [WIDTH-1:0]        lo_r;

    logic [RECODE_BITS-1:0]  recode_bits_s;
    booth_act_t              act_s;
    logic [AW-1:0]           m_ext_s;
    logic [AW-1:0]           m2_s;
    logic [AW-1:0]           addend_s;
    logic [AW-1:0]           sum_s;
    logic signed [AW+WIDTH:0] cat_s;
    logic signed [AW+WIDTH:0] shifted_s;

    assign recode_bits_s = {q_r[RECODE_BITS-2:0], qm1_r};

    booth_recoder u_recoder (
        .bits (recode_bits_s),
        .act  (act_s)
    );

    // Select the Booth addend (0, +/-M, +/-2M) at the extended width.
    always_comb begin
        m_ext_s  = {{2{m_r[WIDTH-1]}}, m_r};
        m2_s     = {m_ext_s[AW-2:0], 1'b0};
        addend_s = {AW{1'b0}};
        case (act_s)
            ACT_ADD_M:  addend_s = m_ext_s;
            ACT_SUB_M:  addend_s = ~m_ext_s + AW'(1);
            ACT_ADD_2M: addend_s = m2_s;
            ACT_SUB_2M: addend_s = ~m2_s + AW'(1);
            default:    addend_s = {AW{1'b0}};
        endcase
    end

    // One Booth step: accumulate, then arithmetic shift of {A, Q, Q-1}.
    always_comb begin
        sum_s     = a_r + addend_s;
        cat_s     = {sum_s, q_r, qm1_r};
        shifted_s = cat_s >>> RADIX_SHIFT;
    end

    // Control FSM, counter, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= {AW{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            qm1_r   <= 1'b0;
            m_r     <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        m_r     <= bus.multiplicand;
                        q_r     <= bus.multiplier;
                        a_r     <= {AW{1'b0}};
                        qm1_r   <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r   <= shifted_s[AW+WIDTH:WIDTH+1];
                    q_r   <= shifted_s[WIDTH:1];
                    qm1_r <= shifted_s[0];
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(STEPS - 1)) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Upper guard bits of A are pure sign extension here.
                    hi_r    <= a_r[WIDTH-1:0];
                    lo_r    <= q_r;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b1;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed vectors, control corner cases, random back-to-back.
module tb_booth_multiplier;

`ifdef BOOTH_BIT_PAIR_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif
    localparam int NR    = 24;
    localparam int BOUND = 200;

    logic clk;
    logic clr;

    booth_multiplier_if #(.WIDTH(32)) bus ();

    booth_multiplier #(.WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] m;
        logic [31:0] q;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one multiply and wait (bounded) for done; operands are scrambled after the start edge.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          output logic [31:0] h, output logic [31:0] l, output int lat);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        lat = 0;
        while (lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
        end
        h = bus.hi;
        l = bus.lo;
    endtask

    // Count done pulses over n cycles with no new start.
    task automatic idle_watch(input int n, output int dones);
        dones = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
    endtask

    initial begin
        logic [31:0] h, l, ph, pl, cm, cq;
        int          lat, dones, cyc;
        logic        got, stable_ok;
        longint      exp;

        vecs[0] = '{"7x-3",        32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{"min_x_min",   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{"min_x_1",     32'h8000_0000,  32'd1,         32'hFFFF_FFFF, 32'h8000_0000};
        vecs[3] = '{"1_x_min",     32'd1,          32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[4] = '{"max_x_max",   32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[5] = '{"m1_x_m1",     32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6] = '{"0_x_const",   32'd0,          32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{"-5x6",        32'hFFFF_FFFB,  32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFE2};

        clr              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = 32'd0;
        bus.multiplier   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);

        // Directed vectors: value, latency, single done pulse, result held.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].m, vecs[i].q, h, l, lat);
            check({vecs[i].name, "_hi"}, {32'd0, h}, {32'd0, vecs[i].hi});
            check({vecs[i].name, "_lo"}, {32'd0, l}, {32'd0, vecs[i].lo});
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(LAT));
            idle_watch(3, dones);
            check({vecs[i].name, "_single_done"}, 64'(dones), 64'd0);
            check({vecs[i].name, "_hold"}, {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
        end

        // start re-pulsed mid-RUN with other operands must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd3; bus.multiplier = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (lat == 6) begin
                bus.start = 1'b1; bus.multiplicand = 32'd100; bus.multiplier = 32'd200;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
        end
        check("repulse_result", {bus.hi, bus.lo}, 64'd12);
        check("repulse_lat", 64'(lat), 64'(LAT));
        idle_watch(LAT + 4, dones);
        check("repulse_no_extra_done", 64'(dones), 64'd0);

        // clr ten cycles into RUN discards the operation and clears outputs.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd9; bus.multiplier = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("clr_busy", {63'd0, bus.busy}, 64'd0);
        check("clr_done", {63'd0, bus.done}, 64'd0);
        check("clr_hilo", {bus.hi, bus.lo}, 64'd0);
        idle_watch(LAT + 4, dones);
        check("clr_discard", 64'(dones), 64'd0);
        run_op(32'd5, 32'd6, h, l, lat);
        check("after_clr_prod", {h, l}, 64'd30);
        check("after_clr_lat", 64'(lat), 64'(LAT));

        // clr together with start: start is not accepted.
        @(negedge clk);
        clr = 1'b1; bus.start = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd7;
        @(posedge clk);
        #1;
        clr = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("clr_start_busy", {63'd0, bus.busy}, 64'd0);
        idle_watch(LAT + 4, dones);
        check("clr_start_no_done", 64'(dones), 64'd0);
        check("clr_start_hilo", {bus.hi, bus.lo}, 64'd0);

        // Random back-to-back: next start is raised during each done cycle.
        ph = 32'd0; pl = 32'd0;
        @(negedge clk);
        cm = pick(); cq = pick();
        bus.start = 1'b1; bus.multiplicand = cm; bus.multiplier = cq;
        for (int i = 0; i < NR; i++) begin
            @(posedge clk);
            #1;
            bus.start        = 1'b0;
            bus.multiplicand = $urandom;
            bus.multiplier   = $urandom;
            cyc = 0; got = 1'b0; stable_ok = 1'b1;
            while (cyc < BOUND && !got) begin
                @(negedge clk);
                cyc++;
                if (bus.done) got = 1'b1;
                else if (bus.hi !== ph || bus.lo !== pl) stable_ok = 1'b0;
            end
            exp = longint'($signed(cm)) * longint'($signed(cq));
            check("rand_prod", {bus.hi, bus.lo}, exp);
            check("rand_lat", 64'(cyc), 64'(LAT));
            check("rand_stable", {63'd0, stable_ok}, 64'd1);
            ph = bus.hi; pl = bus.lo;
            if (i < NR - 1) begin
                cm = pick(); cq = pick();
                bus.start = 1'b1; bus.multiplicand = cm; bus.multiplier = cq;
            end
        end
        idle_watch(LAT + 4, dones);
        check("rand_tail_no_done", 64'(dones), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
